// File: rtl/regfile_wb_arbiter_pkg.sv
// regfile_pkg
//   Shared constants and types for the 32x32 register file and its
//   write-back arbiter. Source index constants name the two write-port
//   producers so grant vectors can be indexed by meaning, not by number.
package regfile_pkg;

  localparam int NREG    = 32;
  localparam int ADDR_W  = 5;
  localparam int DATA_W  = 32;

  localparam int SRC_ALU = 0;   // in-order ALU/load pipeline
  localparam int SRC_MDU = 1;   // multi-cycle multiply/divide unit

  typedef logic [ADDR_W-1:0] regAddr_t;
  typedef logic [DATA_W-1:0] regData_t;
  typedef logic [ADDR_W:0]   regCnt_t;
  typedef logic [NREG-1:0]   regMask_t;

  // One-hot mask selecting a single register.
  function automatic regMask_t oneHot(input regAddr_t addr);
    regMask_t mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if
//   Bundles every non-clock/reset signal of the write-back arbiter.
//   slave  : the arbiter side (takes requests, drives readies/hazards/write port)
//   master : the environment side (producers, issue logic, decode, register file)
//   Signals:
//     s0_*      source 0 (ALU/load) valid/ready/addr/data
//     s1_*      source 1 (MDU) valid/ready/addr/data
//     iss_*     MDU issue request and its ready
//     rd_addrN  decode read addresses, hazardN the matching stall flags
//     rf_*      registered register-file write port
//     pend_cnt  number of registers with an outstanding MDU result
interface regfile_wb_arbiter_if;
  import regfile_pkg::*;

  logic     s0_valid;
  logic     s0_ready;
  regAddr_t s0_addr;
  regData_t s0_data;

  logic     s1_valid;
  logic     s1_ready;
  regAddr_t s1_addr;
  regData_t s1_data;

  logic     iss_valid;
  regAddr_t iss_addr;
  logic     iss_ready;

  regAddr_t rd_addr1;
  regAddr_t rd_addr2;
  logic     hazard1;
  logic     hazard2;

  logic     rf_we;
  regAddr_t rf_waddr;
  regData_t rf_wdata;

  regCnt_t  pend_cnt;

  modport slave (
    input  s0_valid, s0_addr, s0_data,
    input  s1_valid, s1_addr, s1_data,
    input  iss_valid, iss_addr,
    input  rd_addr1, rd_addr2,
    output s0_ready, s1_ready, iss_ready,
    output hazard1, hazard2,
    output rf_we, rf_waddr, rf_wdata,
    output pend_cnt
  );

  modport master (
    output s0_valid, s0_addr, s0_data,
    output s1_valid, s1_addr, s1_data,
    output iss_valid, iss_addr,
    output rd_addr1, rd_addr2,
    input  s0_ready, s1_ready, iss_ready,
    input  hazard1, hazard2,
    input  rf_we, rf_waddr, rf_wdata,
    input  pend_cnt
  );

endinterface

// File: rtl/regfile_wb_arbiter_rr_arbiter2.sv
// rr_arbiter2
//   Two-requester round-robin arbiter.
//   Ports:
//     CLOCK, RESET  clock, asynchronous active-high reset
//     req[1:0]      request per source (index = source number)
//     update        a granted transfer happened this cycle
//     grant[1:0]    one-hot (or zero) grant, combinational
//   lastGrant remembers the source of the most recent transfer; on
//   contention the other source wins. Reset value 1 lets source 0 win the
//   first contention.
module rr_arbiter2
  import regfile_pkg::*;
(
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] grant
);

  logic lastGrant;

  always_comb begin
    // NOTE: default assignment first so every path drives grant; no latch is inferred.
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = lastGrant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    // NOTE: state registers use non-blocking assignments so all flops sample together.
    if (RESET) begin
      lastGrant <= 1'b1;
    end else if (update) begin
      lastGrant <= grant[SRC_MDU];
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-back arbiter and pending-write scoreboard for the single write
//   port of the register file.
//   Ports:
//     CLOCK  clock, rising edge
//     RESET  asynchronous, active-high reset
//     bus    regfile_wb_arbiter_if.slave (see interface header)
//   A source transfer at edge N drives rf_we/rf_waddr/rf_wdata from N to
//   N+1; writes to register 0 are consumed without asserting rf_we. The
//   scoreboard holds one bit per register with an outstanding MDU result.
module regfile_wb_arbiter
  import regfile_pkg::*;
(
  input  logic                 CLOCK,
  input  logic                 RESET,
  regfile_wb_arbiter_if.slave  bus
);

  // ---------------- arbitration ----------------
  logic [1:0] req;
  logic [1:0] grant;
  logic       xfer0;
  logic       xfer1;
  logic       xfer;

  assign req = {bus.s1_valid, bus.s0_valid};

  rr_arbiter2 uArb (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .req    (req),
    .update (xfer),
    .grant  (grant)
  );

  assign xfer0 = req[SRC_ALU] && grant[SRC_ALU];
  assign xfer1 = req[SRC_MDU] && grant[SRC_MDU];
  assign xfer  = xfer0 || xfer1;

  assign bus.s0_ready = grant[SRC_ALU];
  assign bus.s1_ready = grant[SRC_MDU];

  regAddr_t winAddr;
  regData_t winData;

  assign winAddr = xfer1 ? bus.s1_addr : bus.s0_addr;
  assign winData = xfer1 ? bus.s1_data : bus.s0_data;

  // ---------------- write port register ----------------
  logic     rfWe;
  regAddr_t rfWaddr;
  regData_t rfWdata;
  logic     doWrite;

  assign doWrite = xfer && (winAddr != '0);

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      rfWe    <= 1'b0;
      rfWaddr <= '0;
      rfWdata <= '0;
    end else begin
      rfWe <= doWrite;
      if (doWrite) begin
        rfWaddr <= winAddr;
        rfWdata <= winData;
      end
    end
  end

  assign bus.rf_we    = rfWe;
  assign bus.rf_waddr = rfWaddr;
  assign bus.rf_wdata = rfWdata;

  // ---------------- scoreboard ----------------
  regMask_t pending;
  regCnt_t  pendCnt;
  logic     issReady;
  logic     issFire;
  logic     doClear;
  regMask_t setMask;
  regMask_t clrMask;

  assign issReady = !pending[bus.iss_addr];
  assign issFire  = bus.iss_valid && issReady && (bus.iss_addr != '0);

  // A clear only changes the count when the bit is actually set. A same-cycle
  // issue to the same register cannot see the bit set (issReady would be low),
  // so set-wins never double-counts.
  assign doClear  = xfer1 && pending[bus.s1_addr];

  assign setMask  = issFire ? oneHot(bus.iss_addr) : '0;
  assign clrMask  = xfer1   ? oneHot(bus.s1_addr)  : '0;

  always_ff @(posedge CLOCK or posedge RESET) begin
    // NOTE: the scoreboard is a bank of flops, not a RAM, so reset clears it in one step.
    if (RESET) begin
      pending <= '0;
      pendCnt <= '0;
    end else begin
      // Clear first, then set, so a set on the same bit wins.
      pending <= (pending & ~clrMask) | setMask;
      if (issFire && !doClear) begin
        pendCnt <= pendCnt + regCnt_t'(1);
      end else if (!issFire && doClear) begin
        pendCnt <= pendCnt - regCnt_t'(1);
      end
    end
  end

  assign bus.iss_ready = issReady;
  assign bus.pend_cnt  = pendCnt;

  // ---------------- read hazards ----------------
  // The in-flight term covers the cycle where the write is on rf_* but the
  // register file has not yet captured it.
  function automatic logic hazardOf(input regAddr_t a);
    return (a != '0) && (pending[a] || (rfWe && (rfWaddr == a)));
  endfunction

  assign bus.hazard1 = hazardOf(bus.rd_addr1);
  assign bus.hazard2 = hazardOf(bus.rd_addr2);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter
//   Self-checking bench: a table of post-reset arbitration vectors, hand
//   sequences for the scoreboard and reset corner cases, and a randomized
//   run compared against a behavioural model of the write-back rules.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  logic CLOCK = 1'b0;
  logic RESET;

  always #5 CLOCK = ~CLOCK;

  regfile_wb_arbiter_if bus ();

  regfile_wb_arbiter dut (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  typedef struct {
    bit          v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    bit          v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    bit          iv;
    logic [4:0]  ia;
    logic [4:0]  r1a;
    logic [4:0]  r2a;
  } stim_t;

  typedef struct {
    bit          v0;
    logic [4:0]  a0;
    logic [31:0] d0;
    bit          v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    bit          r0;
    bit          r1;
    bit          we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [5:0]  cnt;
  } vec_t;

  function automatic stim_t idleStim();
    stim_t s;
    s = '{default: 0};
    return s;
  endfunction

  // Drive on the falling edge, then settle so combinational outputs can be sampled.
  task automatic apply(input stim_t s);
    @(negedge CLOCK);
    bus.s0_valid  = s.v0;
    bus.s0_addr   = s.a0;
    bus.s0_data   = s.d0;
    bus.s1_valid  = s.v1;
    bus.s1_addr   = s.a1;
    bus.s1_data   = s.d1;
    bus.iss_valid = s.iv;
    bus.iss_addr  = s.ia;
    bus.rd_addr1  = s.r1a;
    bus.rd_addr2  = s.r2a;
    #1;
  endtask

  task automatic advance();
    @(posedge CLOCK);
    #1;
  endtask

  // ---------------- behavioural model ----------------
  bit          pendM [NREG];
  int          lastSrc;
  bit          weM;
  int          waddrM;
  logic [31:0] wdataM;

  function automatic void modelReset();
    foreach (pendM[i]) pendM[i] = 1'b0;
    lastSrc = 1;
    weM     = 1'b0;
    waddrM  = 0;
    wdataM  = '0;
  endfunction

  function automatic int popcount();
    int n = 0;
    foreach (pendM[i]) n += pendM[i];
    return n;
  endfunction

  function automatic bit hazM(input int a);
    return (a != 0) && (pendM[a] || (weM && waddrM == a));
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t  vecs [9];
  stim_t s;
  stim_t rs;

  initial begin
    // Post-reset vectors: contention s0,s1,s0,s1 with losers holding, then
    // solo writes and register-0 writes.
    vecs[0] = vec_t'{1, 5'd1, 32'h11,       1, 5'd2, 32'h22, 1, 0, 1, 5'd1, 32'h11,       6'd0};
    vecs[1] = vec_t'{1, 5'd3, 32'h33,       1, 5'd2, 32'h22, 0, 1, 1, 5'd2, 32'h22,       6'd0};
    vecs[2] = vec_t'{1, 5'd3, 32'h33,       1, 5'd4, 32'h44, 1, 0, 1, 5'd3, 32'h33,       6'd0};
    vecs[3] = vec_t'{1, 5'd6, 32'h66,       1, 5'd4, 32'h44, 0, 1, 1, 5'd4, 32'h44,       6'd0};
    vecs[4] = vec_t'{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 0, 0, 5'd4, 32'h44,       6'd0};
    vecs[5] = vec_t'{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,  1, 0, 1, 5'd5, 32'hDEADBEEF, 6'd0};
    vecs[6] = vec_t'{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  0, 0, 0, 5'd5, 32'hDEADBEEF, 6'd0};
    vecs[7] = vec_t'{0, 5'd0, 32'h0,        1, 5'd0, 32'h77, 0, 1, 0, 5'd5, 32'hDEADBEEF, 6'd0};
    vecs[8] = vec_t'{1, 5'd0, 32'h88,       0, 5'd0, 32'h0,  1, 0, 0, 5'd5, 32'hDEADBEEF, 6'd0};

    // ---------------- reset state ----------------
    RESET = 1'b1;
    s = idleStim();
    s.v0 = 1; s.v1 = 1;
    apply(s);
    check("rst_we", bus.rf_we, 1'b0);
    check("rst_waddr", bus.rf_waddr, 5'd0);
    check("rst_wdata", bus.rf_wdata, 32'd0);
    check("rst_cnt", bus.pend_cnt, 6'd0);
    check("rst_r0", bus.s0_ready, 1'b1);
    check("rst_r1", bus.s1_ready, 1'b0);
    apply(idleStim());
    RESET = 1'b0;

    // ---------------- table vectors ----------------
    for (int i = 0; i < 9; i++) begin
      s = idleStim();
      s.v0 = vecs[i].v0; s.a0 = vecs[i].a0; s.d0 = vecs[i].d0;
      s.v1 = vecs[i].v1; s.a1 = vecs[i].a1; s.d1 = vecs[i].d1;
      apply(s);
      check($sformatf("vec%0d_r0", i), bus.s0_ready, vecs[i].r0);
      check($sformatf("vec%0d_r1", i), bus.s1_ready, vecs[i].r1);
      advance();
      check($sformatf("vec%0d_we", i), bus.rf_we, vecs[i].we);
      check($sformatf("vec%0d_waddr", i), bus.rf_waddr, vecs[i].waddr);
      check($sformatf("vec%0d_wdata", i), bus.rf_wdata, vecs[i].wdata);
      check($sformatf("vec%0d_cnt", i), bus.pend_cnt, vecs[i].cnt);
    end

    // ---------------- scoreboard: issue, WAW stall, clear ----------------
    s = idleStim(); s.iv = 1; s.ia = 5'd7; s.r1a = 5'd7;
    apply(s);
    check("sb_iss_ready", bus.iss_ready, 1'b1);
    check("sb_haz_before", bus.hazard1, 1'b0);
    advance();
    check("sb_cnt1", bus.pend_cnt, 6'd1);
    check("sb_haz_set", bus.hazard1, 1'b1);

    apply(s);
    check("sb_waw_ready", bus.iss_ready, 1'b0);
    advance();
    check("sb_waw_cnt", bus.pend_cnt, 6'd1);

    s = idleStim(); s.v1 = 1; s.a1 = 5'd7; s.d1 = 32'h7777; s.r1a = 5'd7;
    apply(s);
    check("sb_clr_r1", bus.s1_ready, 1'b1);
    advance();
    check("sb_clr_cnt", bus.pend_cnt, 6'd0);
    check("sb_clr_haz_inflight", bus.hazard1, 1'b1);
    check("sb_clr_we", bus.rf_we, 1'b1);

    s = idleStim(); s.r1a = 5'd7; s.r2a = 5'd0;
    apply(s);
    check("sb_haz_r0", bus.hazard2, 1'b0);
    advance();
    check("sb_haz_drop", bus.hazard1, 1'b0);
    check("sb_iss_ready_again", bus.iss_ready, 1'b1);

    // ---------------- same-cycle set and clear ----------------
    s = idleStim(); s.iv = 1; s.ia = 5'd9; s.v1 = 1; s.a1 = 5'd9; s.d1 = 32'h9999; s.r2a = 5'd9;
    apply(s);
    check("sc_iss_ready", bus.iss_ready, 1'b1);
    check("sc_r1", bus.s1_ready, 1'b1);
    advance();
    check("sc_cnt", bus.pend_cnt, 6'd1);
    s = idleStim(); s.r2a = 5'd9;
    apply(s);
    advance();
    check("sc_pending_kept", bus.hazard2, 1'b1);
    check("sc_cnt_hold", bus.pend_cnt, 6'd1);
    s = idleStim(); s.v1 = 1; s.a1 = 5'd9; s.d1 = 32'h1;
    apply(s);
    advance();
    check("sc_final_clear", bus.pend_cnt, 6'd0);

    // ---------------- reset mid-operation ----------------
    for (int k = 3; k <= 5; k++) begin
      s = idleStim(); s.iv = 1; s.ia = 5'(k);
      apply(s);
      advance();
    end
    check("mr_cnt3", bus.pend_cnt, 6'd3);
    s = idleStim(); s.v0 = 1; s.a0 = 5'd10; s.d0 = 32'hA0A0;
    apply(s);
    advance();
    check("mr_we_pre", bus.rf_we, 1'b1);
    @(negedge CLOCK);
    RESET = 1'b1;
    s = idleStim(); s.r1a = 5'd3; s.r2a = 5'd10;
    apply(s);
    check("mr_we", bus.rf_we, 1'b0);
    check("mr_cnt", bus.pend_cnt, 6'd0);
    check("mr_haz1", bus.hazard1, 1'b0);
    check("mr_haz2", bus.hazard2, 1'b0);
    @(negedge CLOCK);
    RESET = 1'b0;
    advance();
    check("mr_no_write", bus.rf_we, 1'b0);
    s = idleStim(); s.v0 = 1; s.a0 = 5'd11; s.d0 = 32'hB1; s.v1 = 1; s.a1 = 5'd12; s.d1 = 32'hC2;
    apply(s);
    check("mr_first_r0", bus.s0_ready, 1'b1);
    check("mr_first_r1", bus.s1_ready, 1'b0);
    advance();
    check("mr_first_waddr", bus.rf_waddr, 5'd11);

    // ---------------- randomized run against the model ----------------
    @(negedge CLOCK);
    RESET = 1'b1;
    apply(idleStim());
    RESET = 1'b0;
    modelReset();
    rs = idleStim();
    for (int c = 0; c < 600; c++) begin
      int win;
      int ia;
      bit issReadyM;
      int wAddr;

      if (!rs.v0 && $urandom_range(0, 1) == 1) begin
        rs.v0 = 1; rs.a0 = 5'($urandom_range(0, 7)); rs.d0 = $urandom;
      end
      if (!rs.v1 && $urandom_range(0, 1) == 1) begin
        rs.v1 = 1; rs.a1 = 5'($urandom_range(0, 7)); rs.d1 = $urandom;
      end
      rs.iv  = ($urandom_range(0, 2) == 0);
      rs.ia  = 5'($urandom_range(0, 7));
      rs.r1a = 5'($urandom_range(0, 7));
      rs.r2a = 5'($urandom_range(0, 7));
      apply(rs);

      // Arbitration rule: a lone requester wins; on contention the one not served last wins.
      if (rs.v0 && rs.v1) win = (lastSrc == 0) ? 1 : 0;
      else if (rs.v0)     win = 0;
      else if (rs.v1)     win = 1;
      else                win = -1;
      ia        = int'(rs.ia);
      issReadyM = !pendM[ia];

      check("rnd_r0", bus.s0_ready, win == 0);
      check("rnd_r1", bus.s1_ready, win == 1);
      check("rnd_iss_ready", bus.iss_ready, issReadyM);
      check("rnd_haz1", bus.hazard1, hazM(int'(rs.r1a)));
      check("rnd_haz2", bus.hazard2, hazM(int'(rs.r2a)));

      if (win == 1) pendM[int'(rs.a1)] = 1'b0;
      if (rs.iv && issReadyM && ia != 0) pendM[ia] = 1'b1;
      if (win >= 0) begin
        lastSrc = win;
        wAddr   = (win == 1) ? int'(rs.a1) : int'(rs.a0);
        if (wAddr != 0) begin
          weM    = 1'b1;
          waddrM = wAddr;
          wdataM = (win == 1) ? rs.d1 : rs.d0;
        end else begin
          weM = 1'b0;
        end
      end else begin
        weM = 1'b0;
      end
      if (win == 0) rs.v0 = 0;
      if (win == 1) rs.v1 = 0;

      advance();
      check("rnd_we", bus.rf_we, weM);
      check("rnd_waddr", bus.rf_waddr, 5'(waddrM));
      check("rnd_wdata", bus.rf_wdata, wdataM);
      check("rnd_cnt", bus.pend_cnt, 6'(popcount()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
